// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the valid/ready pipeline register stage.
package pipe_stage_pkg;

  // Width of the occupancy count (0..2 entries).
  localparam int PIPE_CNT_W = 2;

  // Occupancy-encoded control state; the numeric value equals the number of held entries.
  typedef enum logic [PIPE_CNT_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_BAD   = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One payload register with load enable and synchronous clear to the idle value.
module pipe_data_slot #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  // Clear wins over load so that reset/flush always leave the idle value behind.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      data_q <= INIT_VALUE;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline register stage with valid/ready handshake, optional two-entry skid
// buffer (registered upstream ready), synchronous flush and bubble override.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W          = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE      = '0,
  parameter bit                BUBBLE_OVERRIDE = 1'b0,
  parameter bit                SKID_EN         = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_data,
  input  logic                  i_ready,
  output logic [PIPE_CNT_W-1:0] o_count
);

  pipe_state_e state_q, state_d;

  logic                  accept;
  logic                  fire;
  logic                  mainLoad;
  logic                  skidLoad;
  logic                  slotClear;
  logic [DATA_W-1:0]     mainIn;
  logic [DATA_W-1:0]     mainData;
  logic [DATA_W-1:0]     skidData;
  logic [PIPE_CNT_W-1:0] stateBits;

  assign accept    = i_valid & o_ready;
  assign fire      = o_valid & i_ready;
  assign slotClear = reset | i_flush;
  assign stateBits = state_q;

  // TWO only exists when the skid buffer is present; anything else is treated as empty.
  assign o_valid = (state_q == ST_ONE) || (SKID_EN && (state_q == ST_TWO));
  assign o_count = o_valid ? stateBits : '0;

  // Draining the skid entry moves it into main; otherwise main takes fresh upstream data.
  assign mainIn = (state_q == ST_TWO) ? skidData : i_data;

  // Next-state and load decisions; flush empties the stage and drops the same-cycle accept.
  always_comb begin
    state_d  = state_q;
    mainLoad = 1'b0;
    skidLoad = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            mainLoad = 1'b1;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept) begin
            if (fire || !SKID_EN) begin
              mainLoad = 1'b1;
            end else begin
              skidLoad = 1'b1;
              state_d  = ST_TWO;
            end
          end else if (fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (!SKID_EN) begin
            state_d = ST_EMPTY;
          end else if (fire) begin
            mainLoad = 1'b1;
            state_d  = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; reset returns to EMPTY and the illegal code falls out via state_d.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_data_slot #(
    .DATA_W    (DATA_W),
    .INIT_VALUE(INIT_VALUE)
  ) u_main (
    .clk    (clk),
    .clear_i(slotClear),
    .load_i (mainLoad),
    .data_i (mainIn),
    .data_o (mainData)
  );

  if (SKID_EN) begin : g_skid
    logic ready_q;

    pipe_data_slot #(
      .DATA_W    (DATA_W),
      .INIT_VALUE(INIT_VALUE)
    ) u_skid (
      .clk    (clk),
      .clear_i(slotClear),
      .load_i (skidLoad),
      .data_i (i_data),
      .data_o (skidData)
    );

    // Registered ready breaks the combinational ready chain; it is 1 right after reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        ready_q <= 1'b1;
      end else begin
        ready_q <= (state_d != ST_TWO);
      end
    end

    assign o_ready = ready_q & ~reset;
  end else begin : g_noskid
    assign skidData = INIT_VALUE;
    assign o_ready  = (~o_valid | i_ready) & ~reset;
  end

  assign o_data = (BUBBLE_OVERRIDE && !o_valid) ? INIT_VALUE : mainData;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: dut0 = skid buffer + bubble override, dut1 = single entry, no override.
module tb_pipe_stage_reg;

  localparam logic [31:0] INIT0   = 32'hDEAD_BEEF;
  localparam logic [31:0] INIT1   = 32'h0000_0000;
  localparam logic [1:0]  SKIDCFG = 2'b01;
  localparam logic [1:0]  BUBCFG  = 2'b01;
  localparam int          SBDEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  logic iFlush;
  logic iValid;
  logic [31:0] iData;
  logic [1:0] iReady;
  logic [1:0] oReady;
  logic [1:0] oValid;
  logic [1:0][31:0] oData;
  logic [1:0][1:0] oCount;

  // Reference model: list of held words per DUT plus the last word seen on the output.
  int          mCnt [2];
  logic [31:0] mData [2][2];
  logic [31:0] lastMain [2];
  bit          expValid [2];
  bit          expReady [2];
  logic [1:0]  expCount [2];
  logic [31:0] expData [2];

  logic [31:0] sbMem [2][SBDEPTH];
  int          sbHead [2];
  int          sbTail [2];

  int numChecks = 0;
  int numFails  = 0;
  bit checkEn   = 1'b0;
  int cyc       = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(32), .INIT_VALUE(INIT0), .BUBBLE_OVERRIDE(1'b1), .SKID_EN(1'b1)
  ) dut0 (
    .clk(clk), .reset(reset), .i_flush(iFlush), .i_valid(iValid), .i_data(iData),
    .o_ready(oReady[0]), .o_valid(oValid[0]), .o_data(oData[0]),
    .i_ready(iReady[0]), .o_count(oCount[0])
  );

  pipe_stage_reg #(
    .DATA_W(32), .INIT_VALUE(INIT1), .BUBBLE_OVERRIDE(1'b0), .SKID_EN(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .i_flush(iFlush), .i_valid(iValid), .i_data(iData),
    .o_ready(oReady[1]), .o_valid(oValid[1]), .o_data(oData[1]),
    .i_ready(iReady[1]), .o_count(oCount[1])
  );

  function automatic logic [31:0] initOf(input int d);
    return (d == 0) ? INIT0 : INIT1;
  endfunction

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h, want %h", name, d, cyc, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, publish the model's expectations, then advance the model.
  task automatic applyStimulus(input bit rst, input bit fl, input bit v,
                               input logic [31:0] dt, input bit r0, input bit r1);
    bit acc, fir;
    bit rdy [2];
    rdy[0] = r0;
    rdy[1] = r1;
    reset  = rst;
    iFlush = fl;
    iValid = v;
    iData  = dt;
    iReady = {r1, r0};
    for (int d = 0; d < 2; d++) begin
      expValid[d] = (mCnt[d] > 0);
      expCount[d] = 2'(mCnt[d]);
      if (SKIDCFG[d]) expReady[d] = !rst && (mCnt[d] < 2);
      else            expReady[d] = !rst && ((mCnt[d] == 0) || rdy[d]);
      if (mCnt[d] > 0)    expData[d] = mData[d][0];
      else if (BUBCFG[d]) expData[d] = initOf(d);
      else                expData[d] = lastMain[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst || fl) begin
        mCnt[d]     = 0;
        lastMain[d] = initOf(d);
        sbHead[d]   = sbTail[d];
      end else begin
        acc = v && expReady[d];
        fir = expValid[d] && rdy[d];
        if (fir) begin
          lastMain[d] = mData[d][0];
          mData[d][0] = mData[d][1];
          mCnt[d]--;
        end
        if (acc) begin
          mData[d][mCnt[d]] = dt;
          mCnt[d]++;
          sbMem[d][sbTail[d] % SBDEPTH] = dt;
          sbTail[d]++;
        end
      end
    end
    checkEn = 1'b1;
    cyc++;
    #1;
  endtask

  // Monitor: compare status outputs every cycle and pop the scoreboard on each DUT transfer.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput("o_valid", d, 32'(oValid[d]), 32'(expValid[d]));
        checkOutput("o_ready", d, 32'(oReady[d]), 32'(expReady[d]));
        checkOutput("o_count", d, 32'(oCount[d]), 32'(expCount[d]));
        checkOutput("o_data",  d, oData[d], expData[d]);
        if (oValid[d] && iReady[d]) begin
          if (sbHead[d] == sbTail[d]) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL sb_underflow dut%0d cycle %0d: got word %h, want none", d, cyc, oData[d]);
          end else begin
            checkOutput("fire_data", d, oData[d], sbMem[d][sbHead[d] % SBDEPTH]);
            sbHead[d]++;
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      mCnt[d]     = 0;
      lastMain[d] = initOf(d);
      sbHead[d]   = 0;
      sbTail[d]   = 0;
      mData[d][0] = '0;
      mData[d][1] = '0;
    end

    $display("[TB] reset with input pending");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 32'h1234, 1, 1);
    applyStimulus(0, 0, 0, 32'h0, 1, 1);

    $display("[TB] streaming and no-skid toggling");
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 32'(i), 1, cyc[0]);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 1, 1);

    $display("[TB] backpressure into skid");
    applyStimulus(0, 0, 1, 32'hA, 0, cyc[0]);
    applyStimulus(0, 0, 1, 32'hB, 0, cyc[0]);
    applyStimulus(0, 0, 1, 32'hC, 0, cyc[0]);
    applyStimulus(0, 0, 1, 32'hC, 0, cyc[0]);
    applyStimulus(0, 0, 1, 32'hC, 1, cyc[0]);
    applyStimulus(0, 0, 1, 32'hC, 1, cyc[0]);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 1, 1);

    $display("[TB] flush from full");
    applyStimulus(0, 0, 1, 32'h1, 0, 0);
    applyStimulus(0, 0, 1, 32'h2, 0, 0);
    applyStimulus(0, 1, 1, 32'h55, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 1, 1);

    $display("[TB] idle after single word");
    applyStimulus(0, 0, 1, 32'h77, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'h0, 1, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 9) < 7, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 32'h0, 1, 1);
    for (int d = 0; d < 2; d++) checkOutput("drain_left", d, 32'(sbTail[d] - sbHead[d]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline register stage with a valid/ready handshake on both sides, an optional two-entry skid buffer, synchronous flush, and a bubble-override output value.
- It is the next generation of the plain write-enable register used between core pipeline stages (IF/ID, ID/EX, EX/MEM).
- Stall propagation is done by backpressure instead of hand-wired write enables.
- With SKID_EN=1, upstream ready is a register, which breaks the combinational ready path across stages.

Parameters:
- DATA_W, 32: payload width in bits.
- INIT_VALUE, 0: payload value after reset or flush, and the bubble value.
- BUBBLE_OVERRIDE, 1'b0: when 1, o_data is forced to INIT_VALUE whenever o_valid=0.
- SKID_EN, 1'b1: 1 gives a two-entry skid buffer with registered o_ready. 0 gives a single entry with o_ready = ~o_valid | i_ready (combinational).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- i_flush, input, 1: synchronous flush; discards all held entries and the same-cycle input.
- i_valid, input, 1: upstream data valid.
- i_data, input, DATA_W: upstream payload.
- o_ready, output, 1: stage can accept from upstream.
- o_valid, output, 1: downstream data valid.
- o_data, output, DATA_W: downstream payload.
- i_ready, input, 1: downstream accepts.
- o_count, output, 2: number of held entries (0..2; max 1 when SKID_EN=0).

Behaviour:
- Definitions: accept = i_valid & o_ready; fire = o_valid & i_ready.
- Reset (reset=1 at posedge):
  - State goes to EMPTY; main and skid data go to INIT_VALUE.
  - o_valid=0, o_count=0.
  - o_ready is forced 0 while reset is high and is 1 on the first cycle after reset deasserts.
- Priority: reset > flush > handshake.
- Flush (i_flush=1, reset=0):
  - Next state EMPTY; both data registers get INIT_VALUE.
  - Any accept in the same cycle is dropped. Upstream sees the handshake, so the upstream logic must also flush.
  - o_ready keeps its normal value during the flush cycle.
- Latency: accepted data appears on o_data/o_valid exactly one cycle later. There is no combinational path from i_data to o_data.
- Ordering: strict FIFO. No data is duplicated or lost except on flush or reset.
- State machine, SKID_EN=1 (state encodes occupancy; o_count equals the state value):
  - EMPTY (0): o_valid=0, o_ready=1.
    - accept: main <= i_data, go to ONE.
  - ONE (1): o_valid=1, o_ready=1.
    - accept & fire: main <= i_data, stay in ONE.
    - accept & ~fire: skid <= i_data, go to TWO.
    - ~accept & fire: go to EMPTY.
    - neither: hold.
  - TWO (2): o_valid=1, o_ready=0.
    - fire: main <= skid, go to ONE.
    - ~fire: hold.
  - o_ready is a registered function of state (1 iff next state != TWO), gated by reset.
- State machine, SKID_EN=0: only EMPTY and ONE exist.
  - o_ready = ~o_valid | i_ready, combinational.
  - accept: main <= i_data, next state ONE.
  - fire & ~accept: next state EMPTY.
- Output data:
  - o_data = main when o_valid=1.
  - When o_valid=0: INIT_VALUE if BUBBLE_OVERRIDE=1, otherwise the last main contents (INIT_VALUE after reset or flush).
- Simultaneous events:
  - fire and accept in the same cycle in ONE is a throughput-1 pass-through.
  - In TWO, i_valid is ignored because o_ready=0.
  - In EMPTY, i_ready is a don't-care.
- Illegal state encoding (3): recovers to EMPTY on the next edge.
- Data registers load only on the events listed above; otherwise they hold.

Decomposition:
- Shared package pipe_stage_pkg:
  - State constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Occupancy width constant PIPE_CNT_W=2.
- One natural sub-module, pipe_data_slot:
  - DATA_W-wide register with load enable and synchronous clear-to-INIT_VALUE (driven by reset|flush).
  - Instantiated as main, and as skid when SKID_EN=1 (generate).
- Control FSM lives in the top module.

Test Plan:
1. Reset/bubble. Config: BUBBLE_OVERRIDE=1, INIT_VALUE=32'hDEAD_BEEF. Stimulus: hold reset 3 cycles with i_valid=1, i_data=32'h1234. Required: o_ready=0, o_valid=0, o_count=0 and o_data=32'hDEADBEEF throughout; after deassert, o_ready=1.
2. Streaming. Config: SKID_EN=1. Stimulus: i_ready=1, push 8 back-to-back words 0..7. Required: o_valid rises one cycle after the first accept; o_data sequence 0..7 on consecutive cycles; o_count stays 1; o_ready stays 1.
3. Backpressure. Config: SKID_EN=1. Stimulus: push A=32'hA, B=32'hB with i_ready=0. Required: o_count goes 1 then 2; o_ready=0 after B; then with i_ready=1 the outputs are A then B, o_ready returns to 1 the cycle after A fires, and a held C is not lost.
4. Flush. Config: SKID_EN=1. Stimulus: fill to TWO, then assert i_flush with i_valid=1, i_data=32'h55. Required: next cycle o_valid=0, o_count=0, o_data=INIT_VALUE, and 32'h55 never appears on the output.
5. No-skid mode. Config: SKID_EN=0. Stimulus: toggle i_ready every cycle while i_valid=1. Required: o_ready equals ~o_valid|i_ready on every cycle; o_count is never more than 1; ordering is preserved.
6. Override off. Config: BUBBLE_OVERRIDE=0. Stimulus: pass 32'h77, then go idle. Required: o_valid drops and o_data stays 32'h77 until the next accept.
